fifo_lvl: RTL and testbench
===========================

Name: fifo_lvl

Overview:
- Parametrised synchronous single-clock FIFO; successor to the basic push/pop FIFO used in the vc_vr_converter datapath.
- Adds a fill-level output, programmable almost-full/almost-empty thresholds, a synchronous flush, and guarded push/pop: illegal requests are dropped rather than corrupting pointers.
- Supports any DEPTH >= 2, including non-power-of-2; read data is combinational from storage (show-ahead).

Parameters:
- WIDTH, 8, data word width in bits (>= 1).
- DEPTH, 10, number of storage entries (>= 2, any integer).
- AFULL_THR, DEPTH-2, afull_o asserted when level >= AFULL_THR (1..DEPTH).
- AEMPTY_THR, 2, aempty_o asserted when level <= AEMPTY_THR (0..DEPTH-1).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  synchronous flush: discard all contents.
- push_i  input  1  write request.
- data_i  input  WIDTH  write data.
- pop_i  input  1  read request; consumes the word currently on data_o.
- data_o  output  WIDTH  head-of-queue word; valid while empty_o = 0.
- empty_o  output  1  level == 0.
- full_o  output  1  level == DEPTH.
- afull_o  output  1  level >= AFULL_THR.
- aempty_o  output  1  level <= AEMPTY_THR.
- level_o  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH.

Behaviour:
- Interface: reset is synchronous and active-high on rst_i; one clock, clk_i.
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 with no power-of-2 assumption. A level counter of $clog2(DEPTH+1) bits drives all flags.
- Reset (rst_i = 1 at clk edge):
  - wr_ptr = rd_ptr = level = 0.
  - empty_o = 1, full_o = 0, afull_o = 0, aempty_o = 1, level_o = 0.
  - Storage contents are not reset; data_o is don't-care while empty.
- Priority per edge: rst_i > flush_i > push/pop.
- flush_i: same pointer/level/flag effect as reset; storage untouched. A push in the same cycle is dropped.
- Accepted events:
  - push_acc = push_i & (~full_o | pop_i).
  - pop_acc = pop_i & ~empty_o.
- Push when full with no pop: dropped; pointers and storage unchanged.
- Pop when empty: ignored. A simultaneous push is still accepted, so level goes 0 -> 1; no bypass, and data_o shows the pushed word the next cycle.
- Push and pop both accepted in one cycle (including when full): both pointers advance, level unchanged. The write lands in the slot being freed when full.
- Level update: +1 on push_acc only, -1 on pop_acc only, otherwise held. It never exceeds DEPTH and never goes below 0.
- Latency: a word pushed at edge N is visible on data_o after edge N when the FIFO was empty. Minimum write-to-read latency is 1 cycle.
- data_o = mem[rd_ptr], combinational from storage.
- All flags are combinational decodes of the registered level, so they are glitch-free relative to clk_i.
- Elaboration checks (fatal): DEPTH < 2, AFULL_THR outside 1..DEPTH, AEMPTY_THR outside 0..DEPTH-1.

Optional Feature:
- Macro: FIFO_LVL_ERR_FLAGS_EN.
- When defined, adds two output ports:
  - ovf_o, 1 bit: sticky; set on the edge after a dropped push (push_i & full_o & ~pop_i).
  - udf_o, 1 bit: sticky; set on the edge after pop_i & empty_o.
  - Both are cleared only by rst_i (not by flush_i); reset value 0.
- When undefined, the ports and their logic are absent; dropped requests are silent. Core behaviour is identical in both builds.

Test Plan:
- Reset, DEPTH=10: assert rst_i 2 cycles -> empty_o=1, aempty_o=1, full_o=0, afull_o=0, level_o=0.
- Fill/drain: push 0x01..0x0A in 10 cycles -> full_o=1, afull_o=1 from level 8, level_o=10. Pop 10 -> data_o sequence 0x01..0x0A, empty_o=1 after last pop.
- Full with push: push 0xFF at full, no pop -> level_o stays 10, next pops still 0x01 first. With FIFO_LVL_ERR_FLAGS_EN: ovf_o=1 and stays set.
- Simultaneous at full: push 0x55 with pop -> level_o stays 10, data_o advances. After 9 more pops data_o=0x55; wrap of both pointers across index 9 -> 0 verified.
- Empty with push+pop: push 0x33 with pop on empty -> level_o=1, data_o=0x33 next cycle. With FIFO_LVL_ERR_FLAGS_EN: udf_o=1.
- Flush mid-stream: level 6 plus push 0x77 with flush_i -> level_o=0, empty_o=1. Next push 0x12 then pop -> data_o=0x12. Sticky error flags survive the flush.

Source files
------------

// File: rtl/fifo_lvl_if.sv
// fifo_lvl_if: push/pop/flag bundle for fifo_lvl.
// master = producer/consumer side, slave = FIFO side.
// FIFO_LVL_ERR_FLAGS_EN adds sticky ovf_o/udf_o.
interface fifo_lvl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             flush_i;
  logic             push_i;
  logic [WIDTH-1:0] data_i;
  logic             pop_i;
  logic [WIDTH-1:0] data_o;
  logic             empty_o;
  logic             full_o;
  logic             afull_o;
  logic             aempty_o;
  logic [LW-1:0]    level_o;
`ifdef FIFO_LVL_ERR_FLAGS_EN
  logic             ovf_o;
  logic             udf_o;

  modport master (
    output flush_i, push_i, data_i, pop_i,
    input  data_o, empty_o, full_o,
    input  afull_o, aempty_o, level_o,
    input  ovf_o, udf_o
  );
  modport slave (
    input  flush_i, push_i, data_i, pop_i,
    output data_o, empty_o, full_o,
    output afull_o, aempty_o, level_o,
    output ovf_o, udf_o
  );
`else
  modport master (
    output flush_i, push_i, data_i, pop_i,
    input  data_o, empty_o, full_o,
    input  afull_o, aempty_o, level_o
  );
  modport slave (
    input  flush_i, push_i, data_i, pop_i,
    output data_o, empty_o, full_o,
    output afull_o, aempty_o, level_o
  );
`endif
endinterface

// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock show-ahead FIFO with level, thresholds,
// flush and guarded push/pop; any DEPTH >= 2.
// Ports: clk_i, rst_i (sync, active-high), bus (fifo_lvl_if.slave):
//   flush_i push_i data_i pop_i -> data_o empty_o full_o
//   afull_o aempty_o level_o. Macro FIFO_LVL_ERR_FLAGS_EN adds
//   sticky ovf_o/udf_o (cleared by rst_i only).
module fifo_lvl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 10,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  fifo_lvl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_THR);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_THR);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_lvl: DEPTH must be >= 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_lvl: AFULL_THR out of 1..DEPTH");
  end
  if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_lvl: AEMPTY_THR out of 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic full, empty;
  logic push_acc, pop_acc;
  logic wr_en;

  // Explicit wrap: DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);

  // Push at full is legal only alongside a pop:
  // the write lands in the slot being freed.
  assign push_acc = bus.push_i & (~full | bus.pop_i);
  assign pop_acc  = bus.pop_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wr_en    = 1'b0;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        wr_en    = 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.data_o   = mem_q[rd_ptr_q];
  assign bus.empty_o  = empty;
  assign bus.full_o   = full;
  assign bus.afull_o  = (level_q >= LVL_AF);
  assign bus.aempty_o = (level_q <= LVL_AE);
  assign bus.level_o  = level_q;

`ifdef FIFO_LVL_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky; flush deliberately leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.push_i & full & ~bus.pop_i) ovf_q <= 1'b1;
      if (bus.pop_i & empty)              udf_q <= 1'b1;
    end
  end

  assign bus.ovf_o = ovf_q;
  assign bus.udf_o = udf_q;
`endif
endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed vector table for fifo_lvl, then random
// traffic checked against a queue-based reference model.
module tb_fifo_lvl;
  localparam int W  = 8;
  localparam int D  = 10;
  localparam int AF = 8;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_lvl_if #(.WIDTH(W), .DEPTH(D)) bus();

  fifo_lvl #(
    .WIDTH(W), .DEPTH(D),
    .AFULL_THR(AF), .AEMPTY_THR(AE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    bit       rst;
    bit       flush;
    bit       push;
    bit       pop;
    bit [7:0] din;
    int       lvl;
    bit [7:0] head;
    bit       ovf;
    bit       udf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   e_ovf  = 0;
  bit   e_udf  = 0;

  task automatic add(input bit r, input bit f, input bit pu,
                     input bit po, input int din,
                     input int lvl, input int head);
    vec_t v;
    v.rst = r; v.flush = f; v.push = pu; v.pop = po;
    v.din = 8'(din); v.lvl = lvl; v.head = 8'(head);
    v.ovf = e_ovf; v.udf = e_udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  // Flags follow from the expected level by the threshold rules.
  task automatic chk_state(input string tag, input int idx,
                           input int lvl, input int head,
                           input bit ovf, input bit udf);
    chk({tag, ".level"},  idx, int'(bus.level_o),  lvl);
    chk({tag, ".empty"},  idx, int'(bus.empty_o),  int'(lvl == 0));
    chk({tag, ".full"},   idx, int'(bus.full_o),   int'(lvl == D));
    chk({tag, ".afull"},  idx, int'(bus.afull_o),  int'(lvl >= AF));
    chk({tag, ".aempty"}, idx, int'(bus.aempty_o), int'(lvl <= AE));
    if (lvl > 0)
      chk({tag, ".data"}, idx, int'(bus.data_o), head);
`ifdef FIFO_LVL_ERR_FLAGS_EN
    chk({tag, ".ovf"}, idx, int'(bus.ovf_o), int'(ovf));
    chk({tag, ".udf"}, idx, int'(bus.udf_o), int'(udf));
`else
    if (ovf && udf && lvl < 0) n_chk++;
`endif
  endtask

  task automatic drive(input bit r, input bit f, input bit pu,
                       input bit po, input bit [7:0] din);
    rst         = r;
    bus.flush_i = f;
    bus.push_i  = pu;
    bus.pop_i   = po;
    bus.data_i  = din;
    @(posedge clk);
    #1;
  endtask

  bit [7:0] q[$];
  bit       m_ovf, m_udf;

  initial begin
    bus.flush_i = 1'b0;
    bus.push_i  = 1'b0;
    bus.pop_i   = 1'b0;
    bus.data_i  = '0;

    // Reset for two cycles.
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Fill 0x01..0x0A.
    for (int i = 1; i <= D; i++) add(0, 0, 1, 0, i, i, 1);
    // Push at full, no pop: dropped.
    e_ovf = 1;
    add(0, 0, 1, 0, 8'hFF, D, 1);
    // Drain: head walks 0x02..0x0A.
    for (int k = 1; k <= D; k++) add(0, 0, 0, 1, 0, D - k, k + 1);
    // Refill, then push+pop at full.
    for (int i = 1; i <= D; i++) add(0, 0, 1, 0, i, i, 1);
    add(0, 0, 1, 1, 8'h55, D, 2);
    for (int j = 1; j <= 9; j++)
      add(0, 0, 0, 1, 0, D - j, (j <= 8) ? j + 2 : 8'h55);
    add(0, 0, 0, 1, 0, 0, 0);
    // Push+pop on empty: pop ignored, push taken.
    e_udf = 1;
    add(0, 0, 1, 1, 8'h33, 1, 8'h33);
    add(0, 0, 0, 1, 0, 0, 0);
    // Flush mid-stream with a concurrent push.
    for (int i = 1; i <= 6; i++) add(0, 0, 1, 0, 8'h40 + i, i, 8'h41);
    add(0, 1, 1, 0, 8'h77, 0, 0);
    add(0, 0, 1, 0, 8'h12, 1, 8'h12);
    add(0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].push,
            vecs[i].pop, vecs[i].din);
      chk_state("vec", i, vecs[i].lvl, int'(vecs[i].head),
                vecs[i].ovf, vecs[i].udf);
    end

    // Random traffic against the queue model.
    drive(1, 0, 0, 0, 0);
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    for (int c = 0; c < 3000; c++) begin
      bit       r, f, pu, po;
      bit [7:0] din;
      int       bias;
      bias = ((c / 150) % 3 == 0) ? 80 : (((c / 150) % 3 == 1) ? 30 : 55);
      r   = ($urandom_range(0, 299) == 0);
      f   = ($urandom_range(0, 59) == 0);
      pu  = ($urandom_range(0, 99) < bias);
      po  = ($urandom_range(0, 99) < 100 - bias);
      din = 8'($urandom);
      drive(r, f, pu, po, din);
      if (r) begin
        q.delete();
        m_ovf = 0;
        m_udf = 0;
      end else begin
        if (pu && q.size() == D && !po) m_ovf = 1;
        if (po && q.size() == 0)        m_udf = 1;
        if (f) begin
          q.delete();
        end else if (po && q.size() > 0) begin
          void'(q.pop_front());
          if (pu) q.push_back(din);
        end else if (pu && q.size() < D) begin
          q.push_back(din);
        end
      end
      chk_state("rnd", c, q.size(),
                (q.size() > 0) ? int'(q[0]) : 0, m_ovf, m_udf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
